dmac_read_burst_handler: RTL and testbench
==========================================

DMAC_READ_BURST_HANDLER -- requirements
Module: dmac_read_burst_handler

Interface
REQ-001 SHALL have parameter ADDR_WD, default 32, address width.
REQ-002 SHALL have parameter DATA_WD, default 32, R data width; STRB_WD = DATA_WD/8 derived locally.
REQ-003 SHALL have parameter CHANNEL_COUNT, default 8, DMA channels; CH_WD = max(1,clog2(CHANNEL_COUNT)).
REQ-004 SHALL have parameter MAX_BURST_LEN, default 16, beats per burst; LEN_WD = clog2(MAX_BURST_LEN).
REQ-005 SHALL have parameter CMD_DEPTH, default 4, burst-descriptor FIFO depth (power of 2).
REQ-006 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous, active-high.
REQ-007 SHALL have ports cmd_valid in 1, cmd_ready out 1 (descriptor handshake).
REQ-008 SHALL have ports cmd_chan in CH_WD; cmd_len in LEN_WD (beats-1); cmd_size in 3 (AXI ARSIZE); cmd_addr_lo in clog2(STRB_WD) (start byte lane); cmd_xfer_last in 1 (final burst of transfer).
REQ-009 SHALL have ports m_axi_rvalid in 1, m_axi_rready out 1, m_axi_rdata in DATA_WD, m_axi_rresp in 2, m_axi_rlast in 1.
REQ-010 SHALL have ports data_out_valid out 1, data_out_ready in 1, data_out out DATA_WD, data_out_keep out STRB_WD, data_out_chan out CH_WD, data_out_last out 1 (last beat of burst), data_out_xfer_last out 1.
REQ-011 SHALL have ports rd_resp_valid out 1 (one-cycle pulse), rd_resp_chan out CH_WD, rd_resp_err out 1.

Function
REQ-012 SHALL queue descriptors in issue order; cmd_ready = !fifo_full; push and pop in same cycle both take effect, including when full (pop frees slot next cycle only).
REQ-013 SHALL treat head descriptor as active burst; states IDLE (FIFO empty) and ACTIVE (head present); ACTIVE->IDLE only on final-beat acceptance with FIFO then empty.
REQ-014 SHALL drive m_axi_rready = ACTIVE && (!data_out_valid || data_out_ready); no R beat accepted without a head descriptor.
REQ-015 SHALL register every accepted R beat into a single output stage: latency 1 cycle, full throughput (one beat/cycle) under continuous ready.
REQ-016 SHALL hold data_out* stable while data_out_valid && !data_out_ready.
REQ-017 SHALL maintain lane offset off (init cmd_addr_lo at burst start); per beat: base = off with low cmd_size bits cleared, keep = bytes [off, base+2^cmd_size), next off = (base+2^cmd_size) mod STRB_WD.
REQ-018 SHALL pass data_out = m_axi_rdata unmodified; only data_out_keep reflects valid lanes; cmd_size ≥ clog2(STRB_WD) yields keep all-ones.
REQ-019 SHALL count beats with a LEN_WD counter; beat with count == cmd_len is the final beat, sets data_out_last, data_out_xfer_last = cmd_xfer_last, pops FIFO, resets counter.
REQ-020 SHALL treat the counter as authoritative: m_axi_rlast mismatching (asserted early or missing on final beat) sets burst error; burst boundary unchanged.
REQ-021 SHALL set burst error if any beat has m_axi_rresp[1]=1 (SLVERR/DECERR).
REQ-022 SHALL pulse rd_resp_valid for one cycle, concurrent with final beat appearing on data_out_valid, with rd_resp_chan = burst channel, rd_resp_err = accumulated burst error; error accumulator cleared for next burst.
REQ-023 SHALL support back-to-back bursts: final beat of burst N and first beat of burst N+1 on consecutive cycles.

Reset
REQ-024 SHALL on rst: empty FIFO, counter 0, off 0, error 0; cmd_ready, m_axi_rready, data_out_valid, rd_resp_valid, data_out_last, data_out_xfer_last, rd_resp_err = 0; data/keep/chan outputs 0.
REQ-025 SHALL on rst mid-burst discard in-flight beat and all queued descriptors; cmd_ready = 1 first cycle after rst deasserts.

Verification
REQ-026 Full width: cmd len=3 size=2 addr_lo=0 chan=5, 4 beats -> keep 4'hF x4, last on beat 4 only, rd_resp_valid pulse chan=5 err=0.
REQ-027 Narrow: len=3 size=0 addr_lo=3 -> keep 4'h8, 4'h1, 4'h2, 4'h4.
REQ-028 Unaligned: len=2 size=1 addr_lo=1 -> keep 4'h2, 4'hC, 4'h3.
REQ-029 Backpressure: data_out_ready low 5 cycles mid-burst -> m_axi_rready low while output full, no loss/duplication, order kept.
REQ-030 Errors: rlast on beat 2 of len=3 -> 4 beats still emitted, err=1; rresp=2'b10 on one beat of next burst -> err=1; clean third burst -> err=0.
REQ-031 FIFO: CMD_DEPTH=4, 4 pushes no R -> cmd_ready=0; push+pop same cycle while full keeps count 4; rst mid-burst -> all outputs 0, queued descriptors gone.

Source files
------------

// File: rtl/dmac_read_burst_handler.sv
// AXI read-data burst handler for a DMA engine: descriptor FIFO, lane-keep generation,
// single-stage output register and per-burst response reporting.
module dmac_read_burst_handler #(
  parameter int unsigned ADDR_WD       = 32,
  parameter int unsigned DATA_WD       = 32,
  parameter int unsigned CHANNEL_COUNT = 8,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned CMD_DEPTH     = 4,
  localparam int unsigned STRB_WD = DATA_WD / 8,
  localparam int unsigned CH_WD   = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  localparam int unsigned LEN_WD  = $clog2(MAX_BURST_LEN),
  localparam int unsigned OFF_WD  = $clog2(STRB_WD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CH_WD-1:0]   cmd_chan,
  input  logic [LEN_WD-1:0]  cmd_len,
  input  logic [2:0]         cmd_size,
  input  logic [OFF_WD-1:0]  cmd_addr_lo,
  input  logic               cmd_xfer_last,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready,
  input  logic [DATA_WD-1:0] m_axi_rdata,
  input  logic [1:0]         m_axi_rresp,
  input  logic               m_axi_rlast,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic [DATA_WD-1:0] data_out,
  output logic [STRB_WD-1:0] data_out_keep,
  output logic [CH_WD-1:0]   data_out_chan,
  output logic               data_out_last,
  output logic               data_out_xfer_last,
  output logic               rd_resp_valid,
  output logic [CH_WD-1:0]   rd_resp_chan,
  output logic               rd_resp_err
);

  localparam int unsigned PTR_WD  = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_WD  = PTR_WD + 1;
  localparam int unsigned ENT_WD  = CH_WD + LEN_WD + 3 + OFF_WD + 1;
  localparam int unsigned OFF1_WD = OFF_WD + 1;
  localparam int unsigned KEEP1_WD = STRB_WD + 1;
  localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(CMD_DEPTH);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  if (ADDR_WD < OFF_WD) begin : g_addr_wd_check
    $error("ADDR_WD must cover the byte-lane offset");
  end

  // Descriptor FIFO
  logic [ENT_WD-1:0] fifo_mem [CMD_DEPTH];
  logic [PTR_WD-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_WD-1:0] fifo_cnt_q, fifo_cnt_d;
  logic              fifo_full, push, pop;

  logic [CH_WD-1:0]  h_chan;
  logic [LEN_WD-1:0] h_len;
  logic [2:0]        h_size;
  logic [OFF_WD-1:0] h_lo;
  logic              h_xl;

  logic [0:0]        state_q, state_d;
  logic              beat, final_beat, beat_err;
  logic [LEN_WD-1:0] cnt_q;
  logic [OFF_WD-1:0] off_q, cur_off, next_off;
  logic              err_q;

  logic [OFF1_WD-1:0]  span, base, top;
  logic [KEEP1_WD-1:0] hi_mask, lo_mask;
  logic [STRB_WD-1:0]  keep_d;

  logic               dvalid_q, last_q, xl_q;
  logic [DATA_WD-1:0] data_q;
  logic [STRB_WD-1:0] keep_q;
  logic [CH_WD-1:0]   chan_q, resp_chan_q;
  logic               resp_valid_q, resp_err_q;
  logic               unused_rresp;

  assign unused_rresp = m_axi_rresp[0];

  assign fifo_full = (fifo_cnt_q == FULL_CNT);
  assign cmd_ready = !rst && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = beat && final_beat;

  assign {h_chan, h_len, h_size, h_lo, h_xl} = fifo_mem[rd_ptr_q];

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CNT_WD'(1);
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - CNT_WD'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_chan, cmd_len, cmd_size, cmd_addr_lo, cmd_xfer_last};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      state_q    <= ST_IDLE;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_WD'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_WD'(1);
      fifo_cnt_q <= fifo_cnt_d;
      state_q    <= state_d;
    end
  end

  // ACTIVE exactly while a head descriptor is present
  assign state_d = (fifo_cnt_d != '0) ? ST_ACTIVE : ST_IDLE;

  assign m_axi_rready = !rst && (state_q == ST_ACTIVE) && (!dvalid_q || data_out_ready);
  assign beat         = m_axi_rvalid && m_axi_rready;
  assign final_beat   = (cnt_q == h_len);
  assign beat_err     = m_axi_rresp[1] || (m_axi_rlast != final_beat);

  // Lane keep: bytes from the current offset up to the end of the size-aligned window
  always_comb begin
    cur_off  = (cnt_q == '0) ? h_lo : off_q;
    keep_d   = '1;
    next_off = '0;
    span     = '0;
    base     = '0;
    top      = '0;
    hi_mask  = '0;
    lo_mask  = '0;
    if (h_size < 3'(OFF_WD)) begin
      span     = OFF1_WD'(1) << h_size;
      base     = {1'b0, cur_off} & ~(span - OFF1_WD'(1));
      top      = base + span;
      hi_mask  = (KEEP1_WD'(1) << top) - KEEP1_WD'(1);
      lo_mask  = (KEEP1_WD'(1) << cur_off) - KEEP1_WD'(1);
      keep_d   = STRB_WD'(hi_mask & ~lo_mask);
      next_off = OFF_WD'(top);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      off_q        <= '0;
      err_q        <= 1'b0;
      dvalid_q     <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
      chan_q       <= '0;
      last_q       <= 1'b0;
      xl_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_chan_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (beat) begin
        dvalid_q <= 1'b1;
        data_q   <= m_axi_rdata;
        keep_q   <= keep_d;
        chan_q   <= h_chan;
        last_q   <= final_beat;
        xl_q     <= final_beat && h_xl;
        off_q    <= next_off;
        if (final_beat) begin
          cnt_q        <= '0;
          err_q        <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_chan_q  <= h_chan;
          resp_err_q   <= err_q || beat_err;
        end else begin
          cnt_q <= cnt_q + LEN_WD'(1);
          err_q <= err_q || beat_err;
        end
      end else if (data_out_ready) begin
        dvalid_q <= 1'b0;
      end
    end
  end

  assign data_out_valid     = dvalid_q;
  assign data_out           = data_q;
  assign data_out_keep      = keep_q;
  assign data_out_chan      = chan_q;
  assign data_out_last      = last_q;
  assign data_out_xfer_last = xl_q;
  assign rd_resp_valid      = resp_valid_q;
  assign rd_resp_chan       = resp_chan_q;
  assign rd_resp_err        = resp_err_q;

endmodule

// File: tb/tb_dmac_read_burst_handler.sv
// Bench for dmac_read_burst_handler: queue-based burst model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_dmac_read_burst_handler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_chan = '0;
  logic [3:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_addr_lo = '0;
  logic        cmd_xfer_last = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        data_out_valid;
  logic        data_out_ready = 1'b1;
  logic [31:0] data_out;
  logic [3:0]  data_out_keep;
  logic [2:0]  data_out_chan;
  logic        data_out_last;
  logic        data_out_xfer_last;
  logic        rd_resp_valid;
  logic [2:0]  rd_resp_chan;
  logic        rd_resp_err;

  dmac_read_burst_handler dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_addr_lo(cmd_addr_lo), .cmd_xfer_last(cmd_xfer_last),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready), .data_out(data_out),
    .data_out_keep(data_out_keep), .data_out_chan(data_out_chan),
    .data_out_last(data_out_last), .data_out_xfer_last(data_out_xfer_last),
    .rd_resp_valid(rd_resp_valid), .rd_resp_chan(rd_resp_chan), .rd_resp_err(rd_resp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model
  typedef struct {
    logic [2:0] chan;
    int         len;
    int         size;
    int         lo;
    logic       xl;
  } desc_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [2:0]  chan;
    logic        last;
    logic        xl;
  } beat_t;

  desc_t       mq[$];
  beat_t       eq[$];
  int          m_idx = 0;
  int          m_off = 0;
  logic        m_err = 1'b0;
  logic        exp_rv = 1'b0;
  logic [2:0]  exp_rc = '0;
  logic        exp_re = 1'b0;
  int          cyc = 0;

  logic [3:0]  obs_keep[$];
  logic        obs_last[$];
  logic [31:0] obs_data[$];
  logic [3:0]  obs_resp[$];
  int          obs_cyc[$];

  function automatic logic [3:0] lane_keep(input int off, input int size, output int nxt);
    int n;
    int base;
    logic [3:0] k;
    n = 1 << size;
    k = '0;
    if (n >= 4) begin
      nxt = 0;
      return 4'hF;
    end
    base = off - (off % n);
    for (int b = off; b < base + n; b++) k[b] = 1'b1;
    nxt = (base + n) % 4;
    return k;
  endfunction

  desc_t       cd;
  beat_t       nb;
  int          nxt_off;
  int          cur;
  logic        fin;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      eq.delete();
      m_idx = 0;
      m_off = 0;
      m_err = 1'b0;
      exp_rv = 1'b0;
    end else begin
      chk("out_valid", data_out_valid, eq.size() != 0);
      if (data_out_valid && eq.size() != 0) begin
        chk("out_data", data_out, eq[0].data);
        chk("out_keep", data_out_keep, eq[0].keep);
        chk("out_chan", data_out_chan, eq[0].chan);
        chk("out_last", data_out_last, eq[0].last);
        chk("out_xfer_last", data_out_xfer_last, eq[0].xl);
      end
      chk("resp_valid", rd_resp_valid, exp_rv);
      if (exp_rv && rd_resp_valid) begin
        chk("resp_chan", rd_resp_chan, exp_rc);
        chk("resp_err", rd_resp_err, exp_re);
      end
      if (data_out_valid && !data_out_ready) chk("rready_backpressure", m_axi_rready, 0);
      if (mq.size() == 0) chk("rready_no_head", m_axi_rready, 0);

      if (rd_resp_valid) obs_resp.push_back({rd_resp_chan, rd_resp_err});
      if (data_out_valid && data_out_ready) begin
        obs_keep.push_back(data_out_keep);
        obs_last.push_back(data_out_last);
        obs_data.push_back(data_out);
        obs_cyc.push_back(cyc);
        if (eq.size() != 0) void'(eq.pop_front());
      end

      exp_rv = 1'b0;
      if (m_axi_rvalid && m_axi_rready && mq.size() != 0) begin
        cd = mq[0];
        cur = (m_idx == 0) ? cd.lo : m_off;
        nb.keep = lane_keep(cur, cd.size, nxt_off);
        m_off = nxt_off;
        fin = (m_idx == cd.len);
        m_err = m_err | m_axi_rresp[1] | (m_axi_rlast != fin);
        nb.data = m_axi_rdata;
        nb.chan = cd.chan;
        nb.last = fin;
        nb.xl = fin & cd.xl;
        eq.push_back(nb);
        if (fin) begin
          exp_rv = 1'b1;
          exp_rc = cd.chan;
          exp_re = m_err;
          m_err = 1'b0;
          m_idx = 0;
          void'(mq.pop_front());
        end else begin
          m_idx++;
        end
      end
      if (cmd_valid && cmd_ready) begin
        cd.chan = cmd_chan;
        cd.len = int'(cmd_len);
        cd.size = int'(cmd_size);
        cd.lo = int'(cmd_addr_lo);
        cd.xl = cmd_xfer_last;
        mq.push_back(cd);
      end
    end
  end

  task automatic push_cmd(input logic [2:0] ch, input int len, input int sz, input int lo,
                          input logic xl);
    int n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_chan = ch;
    cmd_len = 4'(len);
    cmd_size = 3'(sz);
    cmd_addr_lo = 2'(lo);
    cmd_xfer_last = xl;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) chk("cmd_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input logic [31:0] base, input int nbeats,
                            input logic [15:0] last_mask, input logic [15:0] err_mask);
    int n;
    @(posedge clk); #1;
    for (int i = 0; i < nbeats; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata = base + 32'(i);
      m_axi_rresp = err_mask[i] ? 2'b10 : 2'b00;
      m_axi_rlast = last_mask[i];
      n = 0;
      @(negedge clk);
      while (!m_axi_rready && n < 200) begin
        n++;
        @(negedge clk);
      end
      if (!m_axi_rready) chk("rbeat_timeout", 0, 1);
      @(posedge clk); #1;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
  endtask

  task automatic clear_logs();
    obs_keep.delete();
    obs_last.delete();
    obs_data.delete();
    obs_resp.delete();
    obs_cyc.delete();
  endtask

  task automatic lit_keeps(input string tag, input int n, input logic [63:0] exp);
    chk({tag, "_nbeats"}, obs_keep.size(), n);
    for (int i = 0; i < n; i++) chk($sformatf("%s_keep%0d", tag, i), obs_keep[i], exp[4*i +: 4]);
  endtask

  task automatic lit_lasts(input string tag, input int n, input logic [15:0] exp);
    for (int i = 0; i < n; i++) chk($sformatf("%s_last%0d", tag, i), obs_last[i], exp[i]);
  endtask

  task automatic lit_resps(input string tag, input int n, input logic [15:0] exp);
    chk({tag, "_nresp"}, obs_resp.size(), n);
    for (int i = 0; i < n; i++) chk($sformatf("%s_resp%0d", tag, i), obs_resp[i], exp[4*i +: 4]);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, {cmd_ready, m_axi_rready, data_out_valid, rd_resp_valid,
                         data_out_last, data_out_xfer_last, rd_resp_err}, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_keep_chan"}, {data_out_keep, data_out_chan, rd_resp_chan}, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);
    chk("rready_idle", m_axi_rready, 0);

    // Full-width burst
    clear_logs();
    push_cmd(3'd5, 3, 2, 0, 1'b1);
    send_beats(32'h0000_00A0, 4, 16'b1000, 16'h0);
    drain();
    lit_keeps("full", 4, 64'hFFFF);
    lit_lasts("full", 4, 16'b1000);
    lit_resps("full", 1, 16'hA);

    // Narrow, byte-sized beats from lane 3
    clear_logs();
    push_cmd(3'd1, 3, 0, 3, 1'b0);
    send_beats(32'h1111_0000, 4, 16'b1000, 16'h0);
    drain();
    lit_keeps("narrow", 4, 64'h4218);
    lit_resps("narrow", 1, 16'h2);

    // Unaligned halfword burst
    clear_logs();
    push_cmd(3'd2, 2, 1, 1, 1'b1);
    send_beats(32'h2222_0000, 3, 16'b100, 16'h0);
    drain();
    lit_keeps("unaligned", 3, 64'h3C2);
    lit_resps("unaligned", 1, 16'h4);

    // Back-to-back bursts
    clear_logs();
    push_cmd(3'd3, 1, 2, 0, 1'b0);
    push_cmd(3'd4, 1, 1, 0, 1'b1);
    send_beats(32'h3333_0000, 4, 16'b1010, 16'h0);
    drain();
    lit_keeps("b2b", 4, 64'hC3FF);
    lit_lasts("b2b", 4, 16'b1010);
    lit_resps("b2b", 2, 16'h86);
    chk("b2b_consecutive", obs_cyc[2] - obs_cyc[1], 1);

    // Output backpressure mid-burst
    clear_logs();
    push_cmd(3'd6, 7, 2, 0, 1'b0);
    fork
      send_beats(32'h4444_0000, 8, 16'h80, 16'h0);
      begin
        repeat (3) @(posedge clk);
        #1 data_out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 data_out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_nbeats", obs_data.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("bp_data%0d", i), obs_data[i], 32'h4444_0000 + i);
    lit_resps("bp", 1, 16'hC);

    // Protocol / response errors
    clear_logs();
    push_cmd(3'd1, 3, 2, 0, 1'b0);
    push_cmd(3'd2, 3, 2, 0, 1'b0);
    push_cmd(3'd3, 3, 2, 0, 1'b1);
    send_beats(32'h5555_0000, 12, 16'h0882, 16'h0020);
    drain();
    chk("err_nbeats", obs_keep.size(), 12);
    lit_lasts("err", 12, 16'h0888);
    lit_resps("err", 3, 16'h653);

    // FIFO full, pop/push interplay, then reset mid-burst
    clear_logs();
    for (int i = 0; i < 4; i++) push_cmd(3'(i), 1, 2, 0, 1'b0);
    @(negedge clk);
    chk("fifo_full_ready", cmd_ready, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_chan = 3'd7;
    cmd_len = 4'd0;
    cmd_size = 3'd2;
    cmd_addr_lo = 2'd0;
    cmd_xfer_last = 1'b1;
    m_axi_rvalid = 1'b1;
    m_axi_rdata = 32'h6666_0000;
    m_axi_rlast = 1'b0;
    @(negedge clk);
    chk("full_hold_ready", cmd_ready, 0);
    @(posedge clk); #1;
    m_axi_rdata = 32'h6666_0001;
    m_axi_rlast = 1'b1;
    @(negedge clk);
    chk("pop_beat_rready", m_axi_rready, 1);
    chk("pop_same_cycle_ready", cmd_ready, 0);
    @(posedge clk); #1;
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    @(negedge clk);
    chk("slot_freed_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("refilled_ready", cmd_ready, 0);
    @(posedge clk); #1;
    m_axi_rvalid = 1'b1;
    m_axi_rdata = 32'h6666_0002;
    @(negedge clk);
    chk("midburst_rready", m_axi_rready, 1);
    @(posedge clk); #1;
    m_axi_rvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset("midburst_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk("post_reset_no_head", m_axi_rready, 0);
    chk("post_reset_out_valid", data_out_valid, 0);
    clear_logs();
    push_cmd(3'd2, 1, 0, 2, 1'b1);
    send_beats(32'h7777_0000, 2, 16'b10, 16'h0);
    drain();
    lit_keeps("post_reset", 2, 64'h84);
    lit_resps("post_reset", 1, 16'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
